axis_bram_master: RTL and testbench

- Streams completed FFT results out of the FFT working BRAM as an AXI-Stream master. It is the read-side counterpart of the bit-reversed AXIS-to-BRAM loader.
- Started by a go pulse from the FFT controller once the last butterfly stage has finished.
- Reads FFT_SIZE complex words, handles the 1-cycle BRAM read latency and downstream backpressure with a 2-entry output buffer, and marks the final beat with tlast.

---
 rtl/axis_bram_master.sv | 160 ++++++++++++++++
 tb/tb_axis_bram_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_master.sv
`default_nettype none
// ============================================================================
// Module      : axis_bram_master
// Description : Streams a completed FFT frame out of the FFT working BRAM as
//               an AXI-Stream master. A go pulse in IDLE starts a frame of
//               FFT_SIZE words, read in natural or bit-reversed order. The
//               1-cycle BRAM read latency and downstream backpressure are
//               absorbed by a 2-entry output FIFO. tlast marks word
//               FFT_SIZE-1.
// Ports       : clk, reset_n            - clock, async active-low reset
//               axis_bram_master_go     - start pulse (sampled in IDLE only)
//               axis_bram_master_busy   - high while a frame is in progress
//               axis_bram_master_done   - pulse when the last beat is accepted
//               axis_mem2m_raddr/re     - BRAM read address / read enable
//               axis_mem2m_rdata        - BRAM data, valid one clock after re
//               axis_fft2out_*          - AXI-Stream master (tkeep all ones)
// Revision    : 1.0 - initial release
// ============================================================================
module axis_bram_master #(
    parameter int FFT_SIZE         = 4096,
    parameter int ADDR_WIDTH       = 12,
    parameter int DATA_WIDTH       = 64,
    parameter int BIT_REVERSE_READ = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    axis_bram_master_go,
    output logic                    axis_bram_master_busy,
    output logic                    axis_bram_master_done,
    output logic [ADDR_WIDTH-1:0]   axis_mem2m_raddr,
    output logic                    axis_mem2m_re,
    input  logic [DATA_WIDTH-1:0]   axis_mem2m_rdata,
    output logic                    axis_fft2out_tvalid,
    input  logic                    axis_fft2out_tready,
    output logic [DATA_WIDTH-1:0]   axis_fft2out_tdata,
    output logic                    axis_fft2out_tlast,
    output logic [DATA_WIDTH/8-1:0] axis_fft2out_tkeep
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_READ = 1'b1;

    // Issue counter is one bit wider than the address so it can hold
    // FFT_SIZE, which is where it saturates.
    localparam logic [ADDR_WIDTH:0] c_FFT_SIZE = (ADDR_WIDTH+1)'(FFT_SIZE);
    localparam logic [ADDR_WIDTH:0] c_LAST_IDX = c_FFT_SIZE - (ADDR_WIDTH+1)'(1);

    logic [0:0]            r_state;
    logic [ADDR_WIDTH:0]   r_issue_cnt;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [DATA_WIDTH-1:0] r_buf_data [0:1];
    logic                  r_buf_last [0:1];
    logic                  r_head;
    logic [1:0]            r_count;

    logic                  w_tvalid;
    logic                  w_pop;
    logic [2:0]            w_occ;
    logic                  w_re;
    logic                  w_done;
    logic                  w_tail;
    logic [ADDR_WIDTH-1:0] w_nat_addr;
    logic [ADDR_WIDTH-1:0] w_raddr;

    assign w_tvalid = (r_count != 2'd0);
    assign w_pop    = w_tvalid & axis_fft2out_tready;

    // Words already committed to this FIFO: buffered plus the one in flight
    // from the BRAM, less the one leaving this cycle. Keeping this below 2
    // before issuing guarantees the FIFO can never overflow.
    assign w_occ = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign w_re = (r_state == c_ST_READ) && (r_issue_cnt < c_FFT_SIZE) &&
                  (w_occ < 3'd2);

    assign w_done = (r_state == c_ST_READ) && w_pop && r_buf_last[r_head];

    // Tail slot; a full FIFO never coincides with a capture.
    assign w_tail = r_head ^ r_count[0];

    assign w_nat_addr = r_issue_cnt[ADDR_WIDTH-1:0];

    generate
        if (BIT_REVERSE_READ != 0) begin : g_bitrev
            for (genvar i = 0; i < ADDR_WIDTH; i++) begin : g_bit
                assign w_raddr[i] = w_nat_addr[ADDR_WIDTH-1-i];
            end
        end else begin : g_natural
            assign w_raddr = w_nat_addr;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= c_ST_IDLE;
            r_issue_cnt     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_buf_data[0]   <= '0;
            r_buf_data[1]   <= '0;
            r_buf_last[0]   <= 1'b0;
            r_buf_last[1]   <= 1'b0;
            r_head          <= 1'b0;
            r_count         <= 2'd0;
        end else begin
            // Exactly one cycle of BRAM latency: a read issued now lands next edge.
            r_inflight      <= w_re;
            r_inflight_last <= w_re && (r_issue_cnt == c_LAST_IDX);

            if (w_re) begin
                r_issue_cnt <= r_issue_cnt + (ADDR_WIDTH+1)'(1);
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (axis_bram_master_go) begin
                        r_state     <= c_ST_READ;
                        r_issue_cnt <= '0;
                        r_head      <= 1'b0;
                        r_count     <= 2'd0;
                    end
                end
                c_ST_READ: begin
                    if (w_done) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase

            if (r_inflight) begin
                r_buf_data[w_tail] <= axis_mem2m_rdata;
                r_buf_last[w_tail] <= r_inflight_last;
            end

            if (w_pop) begin
                r_head <= ~r_head;
            end

            // Simultaneous capture and pop leave the occupancy unchanged.
            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign axis_bram_master_busy = (r_state != c_ST_IDLE);
    assign axis_bram_master_done = w_done;
    assign axis_mem2m_re         = w_re;
    assign axis_mem2m_raddr      = w_raddr;
    assign axis_fft2out_tvalid   = w_tvalid;
    assign axis_fft2out_tdata    = r_buf_data[r_head];
    assign axis_fft2out_tlast    = r_buf_last[r_head];
    assign axis_fft2out_tkeep    = '1;

endmodule
`default_nettype wire

// File: tb/tb_axis_bram_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_bram_master
// Description : Self-checking bench for axis_bram_master with FFT_SIZE=16.
//               Instance 0 reads in natural order, instance 1 in bit-reversed
//               order; each has a BRAM model holding word[i] = i.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_bram_master;

    localparam int c_N  = 16;
    localparam int c_AW = 4;
    localparam int c_DW = 64;

    typedef struct {
        logic [c_AW-1:0] nat;   // expected word/address, natural order
        logic [c_AW-1:0] rev;   // expected word/address, bit-reversed order
        logic            last;  // expected tlast
    } vec_t;

    vec_t vecs [c_N];

    logic            clk;
    logic            reset_n;
    logic            go       [2];
    logic            tready   [2];
    logic            busy     [2];
    logic            done     [2];
    logic [c_AW-1:0] raddr    [2];
    logic            re       [2];
    logic [c_DW-1:0] rdata    [2];
    logic            tvalid   [2];
    logic [c_DW-1:0] tdata    [2];
    logic            tlast    [2];
    logic [7:0]      tkeep    [2];

    int passed;
    int total;

    axis_bram_master #(.FFT_SIZE(c_N), .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW),
                       .BIT_REVERSE_READ(0)) u_dut_nat (
        .clk(clk), .reset_n(reset_n),
        .axis_bram_master_go(go[0]), .axis_bram_master_busy(busy[0]),
        .axis_bram_master_done(done[0]),
        .axis_mem2m_raddr(raddr[0]), .axis_mem2m_re(re[0]),
        .axis_mem2m_rdata(rdata[0]),
        .axis_fft2out_tvalid(tvalid[0]), .axis_fft2out_tready(tready[0]),
        .axis_fft2out_tdata(tdata[0]), .axis_fft2out_tlast(tlast[0]),
        .axis_fft2out_tkeep(tkeep[0])
    );

    axis_bram_master #(.FFT_SIZE(c_N), .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW),
                       .BIT_REVERSE_READ(1)) u_dut_rev (
        .clk(clk), .reset_n(reset_n),
        .axis_bram_master_go(go[1]), .axis_bram_master_busy(busy[1]),
        .axis_bram_master_done(done[1]),
        .axis_mem2m_raddr(raddr[1]), .axis_mem2m_re(re[1]),
        .axis_mem2m_rdata(rdata[1]),
        .axis_fft2out_tvalid(tvalid[1]), .axis_fft2out_tready(tready[1]),
        .axis_fft2out_tdata(tdata[1]), .axis_fft2out_tlast(tlast[1]),
        .axis_fft2out_tkeep(tkeep[1])
    );

    // BRAM models: word[i] = i, one-cycle read latency.
    always_ff @(posedge clk) begin
        if (re[0]) rdata[0] <= {{(c_DW-c_AW){1'b0}}, raddr[0]};
        if (re[1]) rdata[1] <= {{(c_DW-c_AW){1'b0}}, raddr[1]};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Modes: 0 full rate, 1 random backpressure, 2 tready low 20 cycles,
    //        3 extra go at beat 5, 4 reset at beat 7.
    task automatic run_frame(input int sel, input int mode);
        int              beats;
        int              issued;
        int              done_cnt;
        bit              seen_done;
        bit              prev_stall;
        logic [c_DW-1:0] prev_data;
        logic            prev_last;
        logic            pop;
        logic [c_DW-1:0] exp_word;

        beats      = 0;
        issued     = 0;
        done_cnt   = 0;
        seen_done  = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;

        @(negedge clk);
        go[sel] = 1'b1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            go[sel] = (mode == 3 && beats == 5);
            case (mode)
                1:       tready[sel] = ($urandom_range(0, 9) >= 3);
                2:       tready[sel] = (cyc > 20);
                default: tready[sel] = 1'b1;
            endcase
            #1;
            pop = tvalid[sel] & tready[sel];

            if (mode == 0 && cyc == 1)
                check(re[sel] == 1'b1 && raddr[sel] == '0, "first_read", re[sel], 1);
            if (mode == 0 && cyc == 2)
                check(tvalid[sel] == 1'b0, "tvalid_before_e2", tvalid[sel], 0);
            if (mode == 0 && cyc == 3)
                check(tvalid[sel] == 1'b1, "tvalid_after_e2", tvalid[sel], 1);
            if (mode == 2 && cyc == 20) begin
                check(issued == 2, "stall_reads", issued, 2);
                check(tvalid[sel] == 1'b1 && tdata[sel] == '0, "stall_head",
                      tdata[sel], 0);
            end

            if (mode == 4 && beats == 7 && tvalid[sel]) begin
                reset_n = 1'b0;
                #1;
                check(tvalid[sel] == 1'b0, "abort_tvalid", tvalid[sel], 0);
                check(busy[sel] == 1'b0, "abort_busy", busy[sel], 0);
                check(re[sel] == 1'b0, "abort_re", re[sel], 0);
                go[sel]     = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end

            if (re[sel]) begin
                check(issued - beats - int'(pop) < 2, "occupancy", issued - beats, 1);
                if (issued < c_N)
                    check(raddr[sel] == (sel ? vecs[issued].rev : vecs[issued].nat),
                          "raddr", raddr[sel],
                          sel ? vecs[issued].rev : vecs[issued].nat);
                else
                    check(1'b0, "extra_read", issued, c_N);
                issued++;
            end

            if (prev_stall)
                check(tvalid[sel] && tdata[sel] == prev_data && tlast[sel] == prev_last,
                      "hold_stable", tdata[sel], prev_data);

            if (done[sel]) begin
                done_cnt++;
                check(pop && tlast[sel], "done_with_last", {pop, tlast[sel]}, 2'b11);
            end

            if (pop) begin
                if (beats < c_N) begin
                    exp_word = {{(c_DW-c_AW){1'b0}}, sel ? vecs[beats].rev : vecs[beats].nat};
                    check(tdata[sel] == exp_word, "beat_data", tdata[sel], exp_word);
                    check(tlast[sel] == vecs[beats].last, "beat_last", tlast[sel],
                          vecs[beats].last);
                end else begin
                    check(1'b0, "extra_beat", beats, c_N);
                end
                beats++;
            end

            prev_stall = tvalid[sel] & ~tready[sel];
            prev_data  = tdata[sel];
            prev_last  = tlast[sel];

            if (done[sel]) begin
                seen_done = 1'b1;
                if (mode == 0) check(cyc == c_N + 2, "go_to_done", cyc, c_N + 2);
                break;
            end
        end

        if (!seen_done) check(1'b0, "timeout_done", beats, c_N);
        check(beats == c_N, "beat_count", beats, c_N);
        go[sel]     = 1'b0;
        tready[sel] = 1'b1;
        @(negedge clk);
        #1;
        check(busy[sel] == 1'b0, "busy_after_done", busy[sel], 0);
        check(done[sel] == 1'b0 && done_cnt == 1, "single_done", done_cnt, 1);
    endtask

    initial begin
        passed = 0;
        total  = 0;

        vecs[0]  = '{4'd0,  4'd0,  1'b0};
        vecs[1]  = '{4'd1,  4'd8,  1'b0};
        vecs[2]  = '{4'd2,  4'd4,  1'b0};
        vecs[3]  = '{4'd3,  4'd12, 1'b0};
        vecs[4]  = '{4'd4,  4'd2,  1'b0};
        vecs[5]  = '{4'd5,  4'd10, 1'b0};
        vecs[6]  = '{4'd6,  4'd6,  1'b0};
        vecs[7]  = '{4'd7,  4'd14, 1'b0};
        vecs[8]  = '{4'd8,  4'd1,  1'b0};
        vecs[9]  = '{4'd9,  4'd9,  1'b0};
        vecs[10] = '{4'd10, 4'd5,  1'b0};
        vecs[11] = '{4'd11, 4'd13, 1'b0};
        vecs[12] = '{4'd12, 4'd3,  1'b0};
        vecs[13] = '{4'd13, 4'd11, 1'b0};
        vecs[14] = '{4'd14, 4'd7,  1'b0};
        vecs[15] = '{4'd15, 4'd15, 1'b1};

        reset_n   = 1'b0;
        go[0]     = 1'b0;
        go[1]     = 1'b0;
        tready[0] = 1'b1;
        tready[1] = 1'b1;
        #23;

        // Reset state
        check(tvalid[0] == 1'b0 && tlast[0] == 1'b0, "rst_tvalid_tlast", tvalid[0], 0);
        check(re[0] == 1'b0 && busy[0] == 1'b0 && done[0] == 1'b0, "rst_re_busy_done",
              {re[0], busy[0], done[0]}, 0);
        check(tdata[0] == '0 && raddr[0] == '0, "rst_tdata_raddr", tdata[0], 0);
        check(tkeep[0] == 8'hFF, "tkeep", tkeep[0], 8'hFF);

        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_frame(0, 0);   // full rate, natural order
        run_frame(0, 1);   // random backpressure
        run_frame(0, 2);   // tready low for 20 cycles
        run_frame(1, 0);   // bit-reversed order
        run_frame(0, 3);   // stray go mid-frame
        run_frame(0, 4);   // reset at beat 7
        run_frame(0, 0);   // clean frame after abort
        run_frame(1, 1);   // bit-reversed under backpressure

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
